lpif_rx_framer: RTL and testbench

Receive-side framing stage that sits directly upstream of the LPIF boundary. It takes descrambled, deskewed 8-byte symbol words from the PHY receive path and locates TLP and DLLP boundaries from 8b/10b framing K-symbols. It presents the LPIF receive bundle to the link layer: per-byte data and valid, plus start/end strobes for TLPs and DLLPs. It also detects framing errors, handles nullified TLPs and tracks packet state across word boundaries.

---
 rtl/lpif_rx_pkg.sv | 31 +++
 rtl/lpif_rx_byte_step.sv | 111 +++++++++++
 rtl/lpif_rx_framer.sv | 160 ++++++++++++++++
 tb/tb_lpif_rx_framer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_rx_pkg.sv
// Shared constants and types for the LPIF receive framer.
package lpif_rx_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;

  localparam int unsigned DEF_MAX_TLP_BYTES = 4112;
  localparam int unsigned DEF_DLLP_BYTES    = 6;
  localparam int unsigned WORD_BYTES        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_TLP  = 2'd1,
    IN_DLLP = 2'd2
  } rx_frame_state_e;

  // Per-byte framing events; abort marks an error that closed an open packet.
  typedef struct packed {
    logic valid;
    logic tlp_start;
    logic tlp_end;
    logic nullified;
    logic dllp_start;
    logic dllp_end;
    logic err;
    logic abort;
  } byte_evt_t;

endpackage

// File: rtl/lpif_rx_byte_step.sv
// Combinational framing step for one symbol byte; chained across the word.
module lpif_rx_byte_step
  import lpif_rx_pkg::*;
#(
  parameter int unsigned MAX_TLP_BYTES = DEF_MAX_TLP_BYTES,
  parameter int unsigned DLLP_BYTES    = DEF_DLLP_BYTES,
  parameter int unsigned CNT_W         = $clog2(DEF_MAX_TLP_BYTES + 2)
) (
  input  rx_frame_state_e  state,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       rx_byte,
  input  logic             k,
  output rx_frame_state_e  next_state_c,
  output logic [CNT_W-1:0] next_cnt_c,
  output byte_evt_t        evt_c
);

  logic             is_stp;
  logic             is_sdp;
  logic             is_end;
  logic             is_edb;
  logic             restart;
  logic [CNT_W-1:0] cnt_inc;

  assign is_stp = k && (rx_byte == STP);
  assign is_sdp = k && (rx_byte == SDP);
  assign is_end = k && (rx_byte == END);
  assign is_edb = k && (rx_byte == EDB);

  // Counter saturates one past the TLP limit so overflow stays detectable.
  assign cnt_inc = (cnt > CNT_W'(MAX_TLP_BYTES)) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    next_state_c = state;
    next_cnt_c   = cnt;
    evt_c        = '0;
    restart      = 1'b0;

    unique case (state)
      IN_TLP: begin
        if (!k) begin
          if (cnt_inc > CNT_W'(MAX_TLP_BYTES)) begin
            evt_c.err    = 1'b1;
            next_state_c = IDLE;
            next_cnt_c   = '0;
          end else begin
            evt_c.valid = 1'b1;
            next_cnt_c  = cnt_inc;
          end
        end else if (is_end || is_edb) begin
          evt_c.tlp_end   = 1'b1;
          evt_c.nullified = is_edb;
          next_state_c    = IDLE;
          next_cnt_c      = '0;
        end else if (is_stp || is_sdp) begin
          evt_c.err = 1'b1;
          restart   = 1'b1;
        end
      end

      IN_DLLP: begin
        if (!k) begin
          if (cnt_inc > CNT_W'(DLLP_BYTES)) begin
            evt_c.err    = 1'b1;
            next_state_c = IDLE;
            next_cnt_c   = '0;
          end else begin
            evt_c.valid = 1'b1;
            next_cnt_c  = cnt_inc;
          end
        end else if (is_end) begin
          if (cnt == CNT_W'(DLLP_BYTES)) begin
            evt_c.dllp_end = 1'b1;
          end else begin
            evt_c.err = 1'b1;
          end
          next_state_c = IDLE;
          next_cnt_c   = '0;
        end else if (is_edb) begin
          evt_c.err    = 1'b1;
          next_state_c = IDLE;
          next_cnt_c   = '0;
        end else if (is_stp || is_sdp) begin
          evt_c.err = 1'b1;
          restart   = 1'b1;
        end
      end

      IDLE:    restart = 1'b1;
      default: restart = 1'b1;
    endcase

    // Decode from IDLE: normal idle handling, or reinterpreting an offending start token.
    if (restart) begin
      next_state_c = IDLE;
      next_cnt_c   = '0;
      if (is_stp) begin
        next_state_c    = IN_TLP;
        evt_c.tlp_start = 1'b1;
      end else if (is_sdp) begin
        next_state_c     = IN_DLLP;
        evt_c.dllp_start = 1'b1;
      end else if (is_end || is_edb) begin
        evt_c.err = 1'b1;
      end
    end

    evt_c.abort = evt_c.err && ((state == IN_TLP) || (state == IN_DLLP));
  end

endmodule

// File: rtl/lpif_rx_framer.sv
// LPIF receive framer: locates TLP/DLLP boundaries in 8-byte symbol words.
module lpif_rx_framer
  import lpif_rx_pkg::*;
#(
  parameter int unsigned MAX_TLP_BYTES = DEF_MAX_TLP_BYTES,
  parameter int unsigned DLLP_BYTES    = DEF_DLLP_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0][7:0] rx_data,
  input  logic [7:0]      rx_k,
  input  logic            rx_word_valid,
  input  logic            link_up,
  input  logic            rxframe_errmask,
  output logic [7:0][7:0] data,
  output logic [7:0]      valid,
  output logic [8:0]      tlp_start,
  output logic [8:0]      tlp_end,
  output logic [8:0]      dllp_start,
  output logic [8:0]      dllp_end,
  output logic            tlp_nullified,
  output logic            rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(MAX_TLP_BYTES + 2);
  localparam int unsigned NB    = WORD_BYTES;

  rx_frame_state_e  state_q;
  rx_frame_state_e  state_d;
  rx_frame_state_e  word_state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] word_cnt;
  byte_evt_t        evt [NB];
  logic             take;

  logic [NB-1:0] valid_d;
  logic [NB-1:0] tlp_start_d;
  logic [NB-1:0] tlp_end_d;
  logic [NB-1:0] dllp_start_d;
  logic [NB-1:0] dllp_end_d;
  logic [NB-1:0] open_mask;
  logic          nullified_d;
  logic          err_d;

  // Byte 0 sees the registered state; each later byte sees its predecessor's result.
  for (genvar i = 0; i < NB; i++) begin : g_step
    rx_frame_state_e  st_in;
    rx_frame_state_e  st_out;
    logic [CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0] cnt_out;

    if (i == 0) begin : g_head
      assign st_in  = state_q;
      assign cnt_in = cnt_q;
    end else begin : g_link
      assign st_in  = g_step[i-1].st_out;
      assign cnt_in = g_step[i-1].cnt_out;
    end

    lpif_rx_byte_step #(
      .MAX_TLP_BYTES (MAX_TLP_BYTES),
      .DLLP_BYTES    (DLLP_BYTES),
      .CNT_W         (CNT_W)
    ) u_step (
      .state        (st_in),
      .cnt          (cnt_in),
      .rx_byte      (rx_data[i]),
      .k            (rx_k[i]),
      .next_state_c (st_out),
      .next_cnt_c   (cnt_out),
      .evt_c        (evt[i])
    );
  end

  assign word_state = g_step[NB-1].st_out;
  assign word_cnt   = g_step[NB-1].cnt_out;
  assign take       = link_up && rx_word_valid;

  // Merge byte events; an aborted packet loses any start strobe it had in this word.
  always_comb begin
    valid_d      = '0;
    tlp_start_d  = '0;
    tlp_end_d    = '0;
    dllp_start_d = '0;
    dllp_end_d   = '0;
    open_mask    = '0;
    nullified_d  = 1'b0;
    err_d        = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if (evt[i].abort) begin
        tlp_start_d  = tlp_start_d & ~open_mask;
        dllp_start_d = dllp_start_d & ~open_mask;
        open_mask    = '0;
      end
      if (evt[i].tlp_end || evt[i].dllp_end) begin
        open_mask = '0;
      end
      if (evt[i].tlp_start || evt[i].dllp_start) begin
        open_mask    = '0;
        open_mask[i] = 1'b1;
      end
      valid_d[i]      = evt[i].valid;
      tlp_start_d[i]  = evt[i].tlp_start;
      tlp_end_d[i]    = evt[i].tlp_end;
      dllp_start_d[i] = evt[i].dllp_start;
      dllp_end_d[i]   = evt[i].dllp_end;
      nullified_d     = nullified_d | evt[i].nullified;
      err_d           = err_d | evt[i].err;
    end
  end

  // Framing state advances only on accepted words; link down drops any open packet.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!link_up) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (rx_word_valid) begin
      state_d = word_state;
      cnt_d   = word_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data          <= '0;
      valid         <= '0;
      tlp_start     <= '0;
      tlp_end       <= '0;
      dllp_start    <= '0;
      dllp_end      <= '0;
      tlp_nullified <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      if (take) begin
        data <= rx_data;
      end
      valid         <= take ? valid_d : '0;
      tlp_start     <= take ? {1'b0, tlp_start_d} : '0;
      tlp_end       <= take ? {1'b0, tlp_end_d} : '0;
      dllp_start    <= take ? {1'b0, dllp_start_d} : '0;
      dllp_end      <= take ? {1'b0, dllp_end_d} : '0;
      tlp_nullified <= take && nullified_d;
      rx_frame_err  <= take && err_d && !rxframe_errmask;
    end
  end

endmodule

// File: tb/tb_lpif_rx_framer.sv
// Bench for lpif_rx_framer: directed scenarios plus a randomized packet stream.
module tb_lpif_rx_framer;
  import lpif_rx_pkg::*;

  localparam int MAXB = 4112;
  localparam int DLB  = 6;
  localparam logic [7:0] D = 8'hA5;

  typedef struct packed {
    logic [7:0] valid;
    logic [8:0] ts;
    logic [8:0] te;
    logic [8:0] ds;
    logic [8:0] de;
    logic       nul;
    logic       err;
  } obs_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_word_valid;
  logic            link_up;
  logic            rxframe_errmask;
  logic [7:0][7:0] rx_data;
  logic [7:0][7:0] data;
  logic [7:0]      rx_k;
  logic [7:0]      valid;
  logic [8:0]      tlp_start;
  logic [8:0]      tlp_end;
  logic [8:0]      dllp_start;
  logic [8:0]      dllp_end;
  logic            tlp_nullified;
  logic            rx_frame_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_mode;
  int          m_cnt;
  obs_t        got;
  obs_t        exp_o;
  logic [63:0] exp_data;
  logic [8:0]  stream [$];

  lpif_rx_framer dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_k            (rx_k),
    .rx_word_valid   (rx_word_valid),
    .link_up         (link_up),
    .rxframe_errmask (rxframe_errmask),
    .data            (data),
    .valid           (valid),
    .tlp_start       (tlp_start),
    .tlp_end         (tlp_end),
    .dllp_start      (dllp_start),
    .dllp_end        (dllp_end),
    .tlp_nullified   (tlp_nullified),
    .rx_frame_err    (rx_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [63:0] w8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic obs_t mk(input logic [7:0] v, input logic [8:0] ts, te, ds, de,
                              input logic nul, err);
    return {v, ts, te, ds, de, nul, err};
  endfunction

  function automatic obs_t sample();
    return {valid, tlp_start, tlp_end, dllp_start, dllp_end, tlp_nullified, rx_frame_err};
  endfunction

  // Reference framing rules: walk the bytes in wire order with a packet mode and byte count.
  task automatic model_word(input logic [63:0] d, input logic [7:0] k, output obs_t e);
    int         open_at;
    int         limit;
    logic       any_err;
    logic       bad;
    logic       again;
    logic       tok;
    logic [7:0] b;
    e = '0;
    open_at = -1;
    any_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = d[8*i +: 8];
      tok = k[i];
      again = 1'b1;
      while (again) begin
        again = 1'b0;
        bad = 1'b0;
        if (m_mode == 0) begin
          if (tok && b == STP) begin m_mode = 1; m_cnt = 0; e.ts[i] = 1'b1; open_at = i; end
          else if (tok && b == SDP) begin m_mode = 2; m_cnt = 0; e.ds[i] = 1'b1; open_at = i; end
          else if (tok && (b == END || b == EDB)) any_err = 1'b1;
        end else if (!tok) begin
          m_cnt++;
          limit = (m_mode == 1) ? MAXB : DLB;
          if (m_cnt > limit) bad = 1'b1;
          else e.valid[i] = 1'b1;
        end else if (b == END || b == EDB) begin
          if (m_mode == 1) begin
            e.te[i] = 1'b1;
            if (b == EDB) e.nul = 1'b1;
            m_mode = 0;
            open_at = -1;
          end else if (b == END && m_cnt == DLB) begin
            e.de[i] = 1'b1;
            m_mode = 0;
            open_at = -1;
          end else begin
            bad = 1'b1;
          end
        end else if (b == STP || b == SDP) begin
          bad = 1'b1;
          again = 1'b1;
        end
        if (bad) begin
          any_err = 1'b1;
          if (open_at >= 0) begin e.ts[open_at] = 1'b0; e.ds[open_at] = 1'b0; end
          open_at = -1;
          m_mode = 0;
          m_cnt = 0;
        end
      end
    end
    e.err = any_err && !rxframe_errmask;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic wv);
    @(negedge clk);
    rx_data = d;
    rx_k = k;
    rx_word_valid = wv;
    if (reset) begin
      m_mode = 0; m_cnt = 0; exp_o = '0; exp_data = '0;
    end else if (!link_up) begin
      m_mode = 0; m_cnt = 0; exp_o = '0;
    end else if (!wv) begin
      exp_o = '0;
    end else begin
      model_word(d, k, exp_o);
      exp_data = d;
    end
    @(posedge clk);
    #1;
    got = sample();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send({$urandom, $urandom}, 8'($urandom), 1'b1);
    send({$urandom, $urandom}, 8'($urandom), 1'b1);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_outputs got=%h want=0", got); end
    vectors++;
    if (data !== '0) begin miscompares++; $display("FAIL reset_data got=%h want=0", data); end
    reset = 1'b0;
  endtask

  task automatic test_dllp();
    obs_t want;
    send(w8(SDP, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, END), 8'h81, 1'b1);
    want = mk(8'h7E, 9'h0, 9'h0, 9'h001, 9'h080, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL dllp_word got=%h want=%h", got, want); end
  endtask

  task automatic test_tlp_multiword();
    obs_t want;
    send(w8(D, D, D, D, D, STP, D, D), 8'h20, 1'b1);
    want = mk(8'hC0, 9'h020, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL tlp_word1 got=%h want=%h", got, want); end
    send(w8(D, D, D, D, D, D, D, D), 8'h00, 1'b1);
    want = mk(8'hFF, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL tlp_word2 got=%h want=%h", got, want); end
    send(w8(D, D, END, D, D, D, D, D), 8'h04, 1'b1);
    want = mk(8'h03, 9'h0, 9'h004, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL tlp_word3 got=%h want=%h", got, want); end
  endtask

  task automatic test_edb();
    obs_t want;
    send(w8(STP, D, D, D, D, D, D, D), 8'h01, 1'b1);
    send(w8(D, D, D, D, D, D, D, D), 8'h00, 1'b1);
    send(w8(D, EDB, D, D, D, D, D, D), 8'h02, 1'b1);
    want = mk(8'h01, 9'h0, 9'h002, 9'h0, 9'h0, 1'b1, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL edb_nullify got=%h want=%h", got, want); end
  endtask

  task automatic test_dllp_errors();
    obs_t want;
    rxframe_errmask = 1'b0;
    send(w8(SDP, D, D, D, D, D, END, D), 8'h41, 1'b1);
    want = mk(8'h3E, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b1);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL dllp_short got=%h want=%h", got, want); end
    send(w8(D, D, D, D, D, D, D, D), 8'h00, 1'b1);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL err_pulse_width got=%h want=0", got); end
    rxframe_errmask = 1'b1;
    send(w8(SDP, D, D, D, D, D, END, D), 8'h41, 1'b1);
    want = mk(8'h3E, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL dllp_short_masked got=%h want=%h", got, want); end
    rxframe_errmask = 1'b0;
    send(w8(SDP, D, D, D, D, D, D, D), 8'h01, 1'b1);
    want = mk(8'h7E, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b1);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL dllp_long got=%h want=%h", got, want); end
  endtask

  task automatic test_back_to_back();
    obs_t want;
    send(w8(D, D, D, D, D, D, D, STP), 8'h80, 1'b1);
    want = mk(8'h00, 9'h080, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL b2b_open got=%h want=%h", got, want); end
    send(w8(D, END, SDP, D, D, D, D, D), 8'h06, 1'b1);
    want = mk(8'hF9, 9'h0, 9'h002, 9'h004, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL b2b_same_word got=%h want=%h", got, want); end
    send(w8(D, END, D, D, D, D, D, D), 8'h02, 1'b1);
    want = mk(8'h01, 9'h0, 9'h0, 9'h0, 9'h002, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL b2b_dllp_close got=%h want=%h", got, want); end
  endtask

  task automatic test_reset_mid_packet();
    obs_t want;
    send(w8(STP, D, D, D, D, D, D, D), 8'h01, 1'b1);
    send(w8(D, D, D, D, D, D, D, D), 8'h00, 1'b1);
    reset = 1'b1;
    send(w8(D, END, D, D, D, D, D, D), 8'h02, 1'b1);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_mid_pkt got=%h want=0", got); end
    reset = 1'b0;
    send(w8(END, D, D, D, D, D, D, D), 8'h01, 1'b1);
    want = mk(8'h00, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b1);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL end_after_reset got=%h want=%h", got, want); end
  endtask

  task automatic test_link_down();
    obs_t want;
    send(w8(STP, D, D, D, D, D, D, D), 8'h01, 1'b1);
    link_up = 1'b0;
    send(w8(END, D, D, D, D, D, D, D), 8'h01, 1'b1);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL link_down_quiet got=%h want=0", got); end
    link_up = 1'b1;
    send(w8(END, D, D, D, D, D, D, D), 8'h01, 1'b1);
    want = mk(8'h00, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b1);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL link_down_dropped got=%h want=%h", got, want); end
  endtask

  task automatic test_word_valid_low();
    obs_t        want;
    logic [63:0] held;
    held = w8(STP, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    send(held, 8'h01, 1'b1);
    send(w8(END, SDP, EDB, STP, END, SDP, EDB, STP), 8'hFF, 1'b0);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL wv_low_quiet got=%h want=0", got); end
    vectors++;
    if (data !== held) begin miscompares++; $display("FAIL wv_low_data_hold got=%h want=%h", data, held); end
    send(w8(END, D, D, D, D, D, D, D), 8'h01, 1'b1);
    want = mk(8'h00, 9'h0, 9'h001, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wv_low_resume got=%h want=%h", got, want); end
  endtask

  task automatic test_tlp_length_limit();
    obs_t want;
    // Exactly the maximum payload closes cleanly.
    send(w8(D, D, D, D, D, D, D, STP), 8'h80, 1'b1);
    for (int w = 0; w < MAXB / 8; w++) begin
      send({$urandom, $urandom}, 8'h00, 1'b1);
      if (got.err !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL tlp_max_no_err word=%0d got=%h", w, got);
      end
    end
    send(w8(END, D, D, D, D, D, D, D), 8'h01, 1'b1);
    want = mk(8'h00, 9'h0, 9'h001, 9'h0, 9'h0, 1'b0, 1'b0);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL tlp_max_end got=%h want=%h", got, want); end
    // One byte beyond the maximum is a framing error at that byte.
    send(w8(D, D, D, D, D, D, D, STP), 8'h80, 1'b1);
    for (int w = 0; w < MAXB / 8; w++) send({$urandom, $urandom}, 8'h00, 1'b1);
    send(w8(D, D, D, D, D, D, D, D), 8'h00, 1'b1);
    want = mk(8'h00, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b1);
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL tlp_overflow got=%h want=%h", got, want); end
  endtask

  task automatic push_data(input int n);
    for (int j = 0; j < n; j++) stream.push_back({1'b0, 8'($urandom)});
  endtask

  // Append one randomly chosen stream item: good/bad packets, idle data, filler or stray tokens.
  task automatic gen_item();
    int         sel;
    logic [7:0] tok;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: begin stream.push_back({1'b1, SDP}); push_data(6); stream.push_back({1'b1, END}); end
      2: begin stream.push_back({1'b1, SDP}); push_data($urandom_range(0, 9)); stream.push_back({1'b1, END}); end
      3, 4: begin
        stream.push_back({1'b1, STP});
        push_data($urandom_range(0, 30));
        stream.push_back({1'b1, ($urandom_range(0, 3) == 0) ? EDB : END});
      end
      5: push_data($urandom_range(1, 5));
      6: stream.push_back({1'b1, 8'hBC});
      7: begin
        case ($urandom_range(0, 3))
          0: tok = STP;
          1: tok = SDP;
          2: tok = END;
          default: tok = EDB;
        endcase
        stream.push_back({1'b1, tok});
      end
      default: begin stream.push_back({1'b1, STP}); push_data($urandom_range(0, 12)); end
    endcase
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [7:0]  k;
    logic [8:0]  item;
    logic        wv;
    for (int n = 0; n < 3000; n++) begin
      while (stream.size() < 8) gen_item();
      for (int i = 0; i < 8; i++) begin
        item = stream.pop_front();
        k[i] = item[8];
        d[8*i +: 8] = item[7:0];
      end
      wv = ($urandom_range(0, 9) != 0);
      link_up = ($urandom_range(0, 99) != 0);
      reset = ($urandom_range(0, 199) == 0);
      rxframe_errmask = ($urandom_range(0, 3) == 0);
      send(d, k, wv);
      vectors++;
      if (got !== exp_o || data !== exp_data) begin
        miscompares++;
        $display("FAIL random word=%0d got=%h want=%h data=%h want_data=%h", n, got, exp_o, data, exp_data);
      end
    end
    reset = 1'b0;
    link_up = 1'b1;
    rxframe_errmask = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    link_up = 1'b1;
    rxframe_errmask = 1'b0;
    rx_word_valid = 1'b0;
    rx_data = '0;
    rx_k = '0;
    m_mode = 0;
    m_cnt = 0;
    exp_o = '0;
    exp_data = '0;
    test_reset();
    test_dllp();
    test_tlp_multiword();
    test_edb();
    test_dllp_errors();
    test_back_to_back();
    test_reset_mid_packet();
    test_link_down();
    test_word_valid_low();
    test_tlp_length_limit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
